axi_mem_responder: RTL and testbench



---
 rtl/axi_pkg.sv | 18 +
 rtl/axi_mem_responder_if.sv | 62 ++++++
 rtl/axi_mem_array.sv | 33 +++
 rtl/axi_mem_responder.sv | 128 ++++++++++++
 tb/tb_axi_mem_responder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared constants for the AXI memory responder: bus widths, response codes
// and the write/read FSM state encodings.
package axi_pkg;
    localparam int ADDR_W = 29;
    localparam int DATA_W = 256;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;
endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI4 single-beat bus between the DDR3 front-end (master) and the responder (slave).
interface axi_mem_responder_if
    import axi_pkg::*;
#(
    parameter int ID_W = 4
);
    logic [ID_W-1:0]   s_axi_awid;
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic [7:0]        s_axi_awlen;
    logic              s_axi_awvalid;
    logic              s_axi_awready;

    logic [DATA_W-1:0] s_axi_wdata;
    logic [STRB_W-1:0] s_axi_wstrb;
    logic              s_axi_wlast;
    logic              s_axi_wvalid;
    logic              s_axi_wready;

    logic [ID_W-1:0]   s_axi_bid;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;

    logic [ID_W-1:0]   s_axi_arid;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [7:0]        s_axi_arlen;
    logic              s_axi_arvalid;
    logic              s_axi_arready;

    logic [ID_W-1:0]   s_axi_rid;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/axi_mem_array.sv
// 256-bit word array: byte-enabled write port and a registered read port.
// Both ports update with non-blocking assignments on the same edge, so a
// read and write to the same word in one cycle returns the old contents.
module axi_mem_array
    import axi_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [STRB_W-1:0]     wr_strb,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [DATA_W-1:0]     rd_data
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Byte-masked write commit
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Registered read capture; holds its value between captures
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_idx];
    end
endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 responder standing in for the DDR3 controller port. Independent
// write and read FSMs, one outstanding transaction each. Bursts are drained
// and answered with SLVERR without touching the array.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int ID_W       = 4,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_mem_responder_if.slave  bus
);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    logic [1:0]            wstate;
    logic [DEPTH_LOG2-1:0] widx;
    logic                  werr;
    logic [ID_W-1:0]       bid_q;
    logic [1:0]            bresp_q;

    logic [1:0]            rstate;
    logic [DEPTH_LOG2-1:0] ridx;
    logic                  rerr;
    logic [7:0]            beats;
    logic [CNT_W-1:0]      cnt;
    logic [ID_W-1:0]       rid_q;

    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [DEPTH_LOG2-1:0] mem_rd_idx;
    logic [DATA_W-1:0]     mem_q;
    logic                  unused_addr_bits;

    // Ignored byte offset and aliased upper address bits
    assign unused_addr_bits = ^{bus.s_axi_awaddr, bus.s_axi_araddr};

    // Write FSM: address, data beats, response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate  <= W_IDLE;
            widx    <= '0;
            werr    <= 1'b0;
            bid_q   <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            case (wstate)
                W_IDLE: if (bus.s_axi_awvalid) begin
                    bid_q  <= bus.s_axi_awid;
                    widx   <= bus.s_axi_awaddr[5 +: DEPTH_LOG2];
                    werr   <= (bus.s_axi_awlen != 8'd0);
                    wstate <= W_DATA;
                end
                W_DATA: if (bus.s_axi_wvalid && bus.s_axi_wlast) begin
                    bresp_q <= werr ? RESP_SLVERR : RESP_OKAY;
                    wstate  <= W_RESP;
                end
                W_RESP: if (bus.s_axi_bready) wstate <= W_IDLE;
                default: wstate <= W_IDLE;
            endcase
        end
    end

    assign bus.s_axi_awready = (wstate == W_IDLE);
    assign bus.s_axi_wready  = (wstate == W_DATA);
    assign bus.s_axi_bvalid  = (wstate == W_RESP);
    assign bus.s_axi_bid     = bid_q;
    assign bus.s_axi_bresp   = bresp_q;
    assign mem_wr_en         = (wstate == W_DATA) && bus.s_axi_wvalid && !werr;

    // Read FSM: cnt holds cycles left until rvalid; the array is sampled in
    // the last wait cycle so rvalid lands RD_LAT cycles after the AR
    // handshake. RD_LAT=1 samples straight off the AR handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate <= R_IDLE;
            ridx   <= '0;
            rerr   <= 1'b0;
            beats  <= '0;
            cnt    <= '0;
            rid_q  <= '0;
        end else begin
            case (rstate)
                R_IDLE: if (bus.s_axi_arvalid) begin
                    rid_q  <= bus.s_axi_arid;
                    ridx   <= bus.s_axi_araddr[5 +: DEPTH_LOG2];
                    rerr   <= (bus.s_axi_arlen != 8'd0);
                    beats  <= bus.s_axi_arlen;
                    cnt    <= CNT_W'(RD_LAT - 1);
                    rstate <= (RD_LAT == 1) ? R_DATA : R_WAIT;
                end
                R_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) rstate <= R_DATA;
                end
                R_DATA: if (bus.s_axi_rready) begin
                    if (beats == 8'd0) rstate <= R_IDLE;
                    else               beats  <= beats - 8'd1;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign mem_rd_en  = ((rstate == R_IDLE) && bus.s_axi_arvalid && (RD_LAT == 1)) ||
                        ((rstate == R_WAIT) && (cnt == CNT_W'(1)));
    assign mem_rd_idx = (rstate == R_IDLE) ? bus.s_axi_araddr[5 +: DEPTH_LOG2] : ridx;

    // Error beats and idle cycles present zero data; a good read is single-beat
    assign bus.s_axi_arready = (rstate == R_IDLE);
    assign bus.s_axi_rvalid  = (rstate == R_DATA);
    assign bus.s_axi_rid     = rid_q;
    assign bus.s_axi_rresp   = ((rstate == R_DATA) && rerr) ? RESP_SLVERR : RESP_OKAY;
    assign bus.s_axi_rlast   = (rstate == R_DATA) && (beats == 8'd0);
    assign bus.s_axi_rdata   = ((rstate == R_DATA) && !rerr) ? mem_q : '0;

    axi_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_idx  (widx),
        .wr_data (bus.s_axi_wdata),
        .wr_strb (bus.s_axi_wstrb),
        .rd_en   (mem_rd_en),
        .rd_idx  (mem_rd_idx),
        .rd_data (mem_q)
    );
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder (ID_W=4, DEPTH_LOG2=10, RD_LAT=2).
module tb_axi_mem_responder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    localparam logic [255:0] D1   = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] ONES = {256{1'b1}};
    localparam logic [255:0] PART = {{224{1'b1}}, 32'h0000_0000};
    localparam logic [255:0] DA   = {8{32'hA5A5_0001}};
    localparam logic [255:0] DB   = {8{32'h5A5A_0002}};
    localparam logic [255:0] DC   = {8{32'hC0DE_0003}};
    localparam logic [255:0] D3   = {8{32'h3333_7777}};

    axi_mem_responder_if #(.ID_W(4)) bus ();

    axi_mem_responder #(.ID_W(4), .DEPTH_LOG2(10), .RD_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string what);
        checks++;
        errors++;
        $display("FAIL timeout %s", what);
    endtask

    // Drives one write (len+1 beats of the same data); returns bresp/bid
    task automatic axi_write(input logic [28:0] addr, input logic [255:0] data,
                             input logic [31:0] strb, input logic [3:0] id,
                             input logic [7:0] len, output logic [1:0] resp,
                             output logic [3:0] bid);
        int n;
        bus.s_axi_awaddr = addr; bus.s_axi_awid = id; bus.s_axi_awlen = len;
        bus.s_axi_awvalid = 1'b1;
        n = 0;
        while (!bus.s_axi_awready && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("awready");
        tick();
        bus.s_axi_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            bus.s_axi_wdata = data; bus.s_axi_wstrb = strb;
            bus.s_axi_wlast = (b == int'(len)); bus.s_axi_wvalid = 1'b1;
            n = 0;
            while (!bus.s_axi_wready && n < 50) begin tick(); n++; end
            if (n >= 50) timeout("wready");
            tick();
        end
        bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
        n = 0;
        while (!bus.s_axi_bvalid && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("bvalid");
        resp = bus.s_axi_bresp; bid = bus.s_axi_bid;
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0;
    endtask

    // Single-beat read; lat = cycles from AR handshake to rvalid
    task automatic axi_read(input logic [28:0] addr, input logic [3:0] id,
                            output logic [255:0] data, output logic [1:0] resp,
                            output logic last, output logic [3:0] rid, output int lat);
        int n;
        bus.s_axi_araddr = addr; bus.s_axi_arid = id; bus.s_axi_arlen = 8'd0;
        bus.s_axi_arvalid = 1'b1;
        n = 0;
        while (!bus.s_axi_arready && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("arready");
        tick();
        bus.s_axi_arvalid = 1'b0;
        lat = 1;
        while (!bus.s_axi_rvalid && lat < 50) begin tick(); lat++; end
        if (lat >= 50) timeout("rvalid");
        data = bus.s_axi_rdata; resp = bus.s_axi_rresp;
        last = bus.s_axi_rlast; rid = bus.s_axi_rid;
        bus.s_axi_rready = 1'b1;
        tick();
        bus.s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.s_axi_awready, bus.s_axi_arready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready got aw/ar=%b%b want 11", bus.s_axi_awready, bus.s_axi_arready);
        end
        checks++;
        if ({bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_rlast} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valid got w/b/r/last=%b%b%b%b want 0000", bus.s_axi_wready,
                     bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_rlast);
        end
        checks++;
        if ({bus.s_axi_bid, bus.s_axi_bresp, bus.s_axi_rid, bus.s_axi_rresp} !== 12'h000 ||
            bus.s_axi_rdata !== 256'd0) begin
            errors++;
            $display("FAIL reset_fields got bid=%h bresp=%h rid=%h rresp=%h rdata=%h want all 0",
                     bus.s_axi_bid, bus.s_axi_bresp, bus.s_axi_rid, bus.s_axi_rresp, bus.s_axi_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_write_read();
        logic [1:0] resp; logic [3:0] id; logic [255:0] d; logic last; int lat;
        axi_write(29'h40, D1, 32'hFFFF_FFFF, 4'd3, 8'd0, resp, id);
        checks++;
        if (resp !== 2'b00 || id !== 4'd3) begin
            errors++; $display("FAIL full_bresp got resp=%h bid=%h want 0/3", resp, id);
        end
        checks++;
        if (bus.s_axi_awready !== 1'b1) begin
            errors++; $display("FAIL full_awready_back got %b want 1", bus.s_axi_awready);
        end
        axi_read(29'h40, 4'd5, d, resp, last, id, lat);
        checks++;
        if (d !== D1) begin errors++; $display("FAIL full_rdata got %h want %h", d, D1); end
        checks++;
        if (resp !== 2'b00 || last !== 1'b1 || id !== 4'd5) begin
            errors++; $display("FAIL full_rmeta got rresp=%h rlast=%b rid=%h want 0/1/5", resp, last, id);
        end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL full_rd_latency got %0d want 2", lat); end
    endtask

    task automatic test_partial_strobe();
        logic [1:0] resp; logic [3:0] id; logic [255:0] d; logic last; int lat;
        axi_write(29'h40, ONES, 32'hFFFF_FFFF, 4'd1, 8'd0, resp, id);
        axi_write(29'h40, 256'd0, 32'h0000_000F, 4'd1, 8'd0, resp, id);
        axi_read(29'h40, 4'd1, d, resp, last, id, lat);
        checks++;
        if (d !== PART) begin errors++; $display("FAIL partial_rdata got %h want %h", d, PART); end
    endtask

    task automatic test_backpressure();
        logic [255:0] d; logic [1:0] resp; logic [3:0] id; logic last; int lat;
        int bad;
        // write word 3 and read word 2 concurrently
        bus.s_axi_awaddr = 29'h60; bus.s_axi_awid = 4'd7; bus.s_axi_awlen = 8'd0;
        bus.s_axi_araddr = 29'h40; bus.s_axi_arid = 4'd9; bus.s_axi_arlen = 8'd0;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_wdata = D3; bus.s_axi_wstrb = 32'hFFFF_FFFF;
        bus.s_axi_wlast = 1'b1; bus.s_axi_wvalid = 1'b1;
        tick();
        bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
        // offer new requests while responses are stalled
        bus.s_axi_awid = 4'd2; bus.s_axi_arid = 4'd4;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.s_axi_bvalid !== 1'b1 || bus.s_axi_rvalid !== 1'b1 || bus.s_axi_bid !== 4'd7 ||
                bus.s_axi_rid !== 4'd9 || bus.s_axi_rdata !== PART ||
                bus.s_axi_awready !== 1'b0 || bus.s_axi_arready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d got bv=%b rv=%b bid=%h rid=%h awr=%b arr=%b rdata=%h want 1 1 7 9 0 0 %h",
                         c, bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_bid, bus.s_axi_rid,
                         bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_rdata, PART);
            end
            tick();
        end
        bus.s_axi_awvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
        checks++;
        if ({bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_awready, bus.s_axi_arready} !== 4'b0011) begin
            errors++;
            $display("FAIL backpressure_release got bv/rv/awr/arr=%b%b%b%b want 0011", bus.s_axi_bvalid,
                     bus.s_axi_rvalid, bus.s_axi_awready, bus.s_axi_arready);
        end
        axi_read(29'h60, 4'd0, d, resp, last, id, lat);
        checks++;
        if (d !== D3) begin errors++; $display("FAIL backpressure_wr_landed got %h want %h", d, D3); end
    endtask

    task automatic test_burst_error();
        logic [1:0] resp; logic [3:0] id; logic [255:0] d; logic last; int lat; int n;
        axi_write(29'h40, 256'd0, 32'hFFFF_FFFF, 4'd6, 8'd3, resp, id);
        checks++;
        if (resp !== 2'b10 || id !== 4'd6) begin
            errors++; $display("FAIL burst_bresp got resp=%h bid=%h want 2/6", resp, id);
        end
        axi_read(29'h40, 4'd0, d, resp, last, id, lat);
        checks++;
        if (d !== PART) begin errors++; $display("FAIL burst_mem_unchanged got %h want %h", d, PART); end
        // two-beat read burst
        bus.s_axi_araddr = 29'h40; bus.s_axi_arid = 4'd8; bus.s_axi_arlen = 8'd1;
        bus.s_axi_arvalid = 1'b1;
        tick();
        bus.s_axi_arvalid = 1'b0;
        n = 0;
        while (!bus.s_axi_rvalid && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("burst rvalid");
        checks++;
        if (bus.s_axi_rdata !== 256'd0 || bus.s_axi_rresp !== 2'b10 || bus.s_axi_rlast !== 1'b0 ||
            bus.s_axi_rid !== 4'd8) begin
            errors++;
            $display("FAIL burst_beat0 got rdata=%h rresp=%h rlast=%b rid=%h want 0/2/0/8",
                     bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast, bus.s_axi_rid);
        end
        bus.s_axi_rready = 1'b1;
        tick();
        checks++;
        if (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rdata !== 256'd0 || bus.s_axi_rresp !== 2'b10 ||
            bus.s_axi_rlast !== 1'b1) begin
            errors++;
            $display("FAIL burst_beat1 got rvalid=%b rdata=%h rresp=%h rlast=%b want 1/0/2/1",
                     bus.s_axi_rvalid, bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast);
        end
        tick();
        bus.s_axi_rready = 1'b0;
        checks++;
        if (bus.s_axi_rvalid !== 1'b0 || bus.s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL burst_done got rvalid=%b arready=%b want 0/1", bus.s_axi_rvalid, bus.s_axi_arready);
        end
    endtask

    task automatic test_concurrency_alias();
        logic [1:0] resp; logic [3:0] id; logic [255:0] d; logic last; int lat;
        axi_write(29'hA0, DA, 32'hFFFF_FFFF, 4'd0, 8'd0, resp, id);
        // AW and AR together: W commit and read capture fall in the same cycle
        bus.s_axi_awaddr = 29'hA0; bus.s_axi_awid = 4'd1; bus.s_axi_awlen = 8'd0;
        bus.s_axi_araddr = 29'hA0; bus.s_axi_arid = 4'd2; bus.s_axi_arlen = 8'd0;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_wdata = DB; bus.s_axi_wstrb = 32'hFFFF_FFFF;
        bus.s_axi_wlast = 1'b1; bus.s_axi_wvalid = 1'b1;
        tick();
        bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
        checks++;
        if (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rdata !== DA) begin
            errors++; $display("FAIL rbw_old_data got rvalid=%b rdata=%h want 1/%h",
                               bus.s_axi_rvalid, bus.s_axi_rdata, DA);
        end
        bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
        axi_read(29'hA0, 4'd0, d, resp, last, id, lat);
        checks++;
        if (d !== DB) begin errors++; $display("FAIL rbw_new_data got %h want %h", d, DB); end
        axi_write(29'h20 + (29'd1 << 15), DC, 32'hFFFF_FFFF, 4'd0, 8'd0, resp, id);
        axi_read(29'h20, 4'd0, d, resp, last, id, lat);
        checks++;
        if (d !== DC) begin errors++; $display("FAIL alias_word1 got %h want %h", d, DC); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [3:0] id; logic [255:0] d; logic last; int lat;
        bus.s_axi_araddr = 29'hA0; bus.s_axi_arid = 4'd3; bus.s_axi_arlen = 8'd0;
        bus.s_axi_arvalid = 1'b1;
        tick();
        bus.s_axi_arvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.s_axi_rvalid !== 1'b0 || bus.s_axi_arready !== 1'b1) begin
            errors++; $display("FAIL reset_mid got rvalid=%b arready=%b want 0/1",
                               bus.s_axi_rvalid, bus.s_axi_arready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.s_axi_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_dropped got rvalid=%b want 0", bus.s_axi_rvalid);
        end
        axi_read(29'hA0, 4'd4, d, resp, last, id, lat);
        checks++;
        if (d !== DB || resp !== 2'b00 || id !== 4'd4 || lat !== 2) begin
            errors++; $display("FAIL reset_mid_after got rdata=%h rresp=%h rid=%h lat=%0d want %h/0/4/2",
                               d, resp, id, lat, DB);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0;
        test_reset();
        test_full_write_read();
        test_partial_strobe();
        test_backpressure();
        test_burst_error();
        test_concurrency_alias();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
